// File: rtl/song_sequencer.sv
// Playback controller for two registered note ROMs: drives the shared address,
// paces one note per BEAT_TICKS cycles, and handles play/pause/restart/loop.
module song_sequencer #(
    parameter int BEAT_TICKS = 12500000,
    parameter int SONG1_LEN  = 84,
    parameter int SONG2_LEN  = 243
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play_pause,
    input  logic       restart,
    input  logic       song_sel,
    input  logic       loop_en,
    input  logic [7:0] rom1_note,
    input  logic [7:0] rom2_note,
    output logic [7:0] rom_addr,
    output logic [7:0] note_out,
    output logic       note_valid,
    output logic       playing,
    output logic       paused,
    output logic       active_song,
    output logic       song_done
);

    localparam int CW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    // PLAY lasts BEAT_TICKS-2 cycles; the two FETCH cycles complete the beat.
    localparam logic [CW-1:0] CNT_END = CW'(BEAT_TICKS - 3);
    localparam logic [7:0]    LAST1   = 8'(SONG1_LEN - 1);
    localparam logic [7:0]    LAST2   = 8'(SONG2_LEN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          fetch_ph;
    logic          pending;
    logic [7:0]    last_idx;
    logic [7:0]    sel_note;
    logic          step_end;

    assign last_idx   = active_song ? LAST2 : LAST1;
    assign sel_note   = active_song ? rom2_note : rom1_note;
    assign step_end   = (cnt == CNT_END);
    assign note_valid = (note_out != 8'd0) && (state == FETCH || state == PLAY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= 8'd0;
            note_out    <= 8'd0;
            cnt         <= '0;
            fetch_ph    <= 1'b0;
            pending     <= 1'b0;
            active_song <= 1'b0;
            playing     <= 1'b0;
            paused      <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (restart || (state == IDLE && play_pause)) begin
                active_song <= song_sel;
                rom_addr    <= 8'd0;
                cnt         <= '0;
                fetch_ph    <= 1'b0;
                pending     <= 1'b0;
                state       <= FETCH;
                playing     <= 1'b1;
                paused      <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (play_pause)
                            pending <= 1'b1;
                        if (fetch_ph) begin
                            note_out <= sel_note;
                            fetch_ph <= 1'b0;
                            state    <= PLAY;
                        end else begin
                            fetch_ph <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (play_pause || pending) begin
                            pending <= 1'b0;
                            state   <= PAUSE;
                            paused  <= 1'b1;
                        end else if (step_end) begin
                            cnt      <= '0;
                            fetch_ph <= 1'b0;
                            if (rom_addr != last_idx) begin
                                rom_addr <= rom_addr + 8'd1;
                                state    <= FETCH;
                            end else begin
                                song_done <= 1'b1;
                                rom_addr  <= 8'd0;
                                if (loop_en) begin
                                    state <= FETCH;
                                end else begin
                                    state    <= IDLE;
                                    note_out <= 8'd0;
                                    playing  <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (play_pause) begin
                            state  <= PLAY;
                            paused <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: instance a uses full-length songs, instance b a 3-entry song 1
// for loop wrap checks. Both share stimulus and see identical registered ROMs.
module tb_song_sequencer;

    logic clk = 1'b0;
    logic rst_n, play_pause, restart, song_sel, loop_en;
    logic [7:0] a_r1, a_r2, a_addr, a_note;
    logic       a_valid, a_playing, a_paused, a_active, a_done;
    logic [7:0] b_r1, b_r2, b_addr, b_note;
    logic       b_valid, b_playing, b_paused, b_active, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom1f(input logic [7:0] a);
        case (a)
            8'd0, 8'd2, 8'd4: return 8'd29;
            8'd1, 8'd3, 8'd5: return 8'd0;
            8'd6:             return 8'd34;
            default:          return a + 8'd40;
        endcase
    endfunction

    function automatic logic [7:0] rom2f(input logic [7:0] a);
        case (a)
            8'd0, 8'd240:  return 8'd25;
            8'd241, 8'd242: return 8'd0;
            default:       return a + 8'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        a_r1 <= rom1f(a_addr);
        a_r2 <= rom2f(a_addr);
        b_r1 <= rom1f(b_addr);
        b_r2 <= rom2f(b_addr);
    end

    song_sequencer #(.BEAT_TICKS(4), .SONG1_LEN(84), .SONG2_LEN(243)) u_a (
        .clk(clk), .rst_n(rst_n), .play_pause(play_pause), .restart(restart),
        .song_sel(song_sel), .loop_en(loop_en), .rom1_note(a_r1), .rom2_note(a_r2),
        .rom_addr(a_addr), .note_out(a_note), .note_valid(a_valid), .playing(a_playing),
        .paused(a_paused), .active_song(a_active), .song_done(a_done)
    );

    song_sequencer #(.BEAT_TICKS(4), .SONG1_LEN(3), .SONG2_LEN(243)) u_b (
        .clk(clk), .rst_n(rst_n), .play_pause(play_pause), .restart(restart),
        .song_sel(song_sel), .loop_en(loop_en), .rom1_note(b_r1), .rom2_note(b_r2),
        .rom_addr(b_addr), .note_out(b_note), .note_valid(b_valid), .playing(b_playing),
        .paused(b_paused), .active_song(b_active), .song_done(b_done)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_pp();
        play_pause = 1'b1;
        cyc(1);
        play_pause = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [7:0] seq1 [0:6];

    initial begin
        seq1[0] = 8'd29; seq1[1] = 8'd0;  seq1[2] = 8'd29; seq1[3] = 8'd0;
        seq1[4] = 8'd29; seq1[5] = 8'd0;  seq1[6] = 8'd34;
        rst_n = 1'b0; play_pause = 1'b0; restart = 1'b0; song_sel = 1'b0; loop_en = 1'b0;
        cyc(2);
        chk("rst_addr",    32'(a_addr), 0);
        chk("rst_note",    32'(a_note), 0);
        chk("rst_valid",   32'(a_valid), 0);
        chk("rst_playing", 32'(a_playing), 0);
        chk("rst_paused",  32'(a_paused), 0);
        chk("rst_active",  32'(a_active), 0);
        chk("rst_done",    32'(a_done), 0);
        rst_n = 1'b1;
        cyc(1);

        // basic playback of song 1
        pulse_pp();
        chk("start_playing", 32'(a_playing), 1);
        chk("start_addr",    32'(a_addr), 0);
        chk("start_note",    32'(a_note), 0);
        cyc(2);
        chk("first_note",  32'(a_note), 29);
        chk("first_valid", 32'(a_valid), 1);
        for (int k = 1; k <= 6; k++) begin
            cyc(4);
            chk($sformatf("seq_note%0d", k),  32'(a_note), 32'(seq1[k]));
            chk($sformatf("seq_valid%0d", k), 32'(a_valid), (seq1[k] != 0) ? 1 : 0);
            chk($sformatf("seq_addr%0d", k),  32'(a_addr), 32'(k));
        end

        // pause at cnt=1 of index 6, hold, resume
        cyc(1);
        pulse_pp();
        chk("pause_paused", 32'(a_paused), 1);
        chk("pause_valid",  32'(a_valid), 0);
        chk("pause_note",   32'(a_note), 34);
        cyc(10);
        chk("hold_addr",   32'(a_addr), 6);
        chk("hold_paused", 32'(a_paused), 1);
        chk("hold_note",   32'(a_note), 34);
        pulse_pp();
        chk("resume_paused", 32'(a_paused), 0);
        chk("resume_valid",  32'(a_valid), 1);
        chk("resume_addr",   32'(a_addr), 6);
        cyc(1);
        chk("resume_step_addr", 32'(a_addr), 7);
        chk("resume_step_note", 32'(a_note), 34);
        cyc(2);
        chk("idx7_note", 32'(a_note), 47);

        // restart to song 2 at index 20, together with play_pause
        cyc(52);
        chk("idx20_addr", 32'(a_addr), 20);
        chk("idx20_note", 32'(a_note), 60);
        song_sel = 1'b1; restart = 1'b1; play_pause = 1'b1;
        cyc(1);
        restart = 1'b0; play_pause = 1'b0;
        chk("rs_active", 32'(a_active), 1);
        chk("rs_addr",   32'(a_addr), 0);
        chk("rs_paused", 32'(a_paused), 0);
        chk("rs_note",   32'(a_note), 60);
        cyc(2);
        chk("rs_new_note", 32'(a_note), 25);
        chk("rs_paused2",  32'(a_paused), 0);
        song_sel = 1'b0;

        // song 2 to the end without loop
        cyc(960);
        chk("s2_240_addr", 32'(a_addr), 240);
        chk("s2_240_note", 32'(a_note), 25);
        cyc(8);
        chk("s2_242_addr", 32'(a_addr), 242);
        chk("s2_242_note", 32'(a_note), 0);
        cyc(1);
        chk("s2_pre_done", 32'(a_done), 0);
        cyc(1);
        chk("s2_done",    32'(a_done), 1);
        chk("s2_playing", 32'(a_playing), 0);
        chk("s2_note",    32'(a_note), 0);
        chk("s2_addr",    32'(a_addr), 0);
        cyc(1);
        chk("s2_done_once", 32'(a_done), 0);

        // loop with a 3-entry song 1 on instance b
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; loop_en = 1'b1;
        pulse_pp();
        cyc(2);
        chk("lp_n0", 32'(b_note), 29);
        chk("lp_a0", 32'(b_addr), 0);
        cyc(4);
        chk("lp_n1", 32'(b_note), 0);
        chk("lp_a1", 32'(b_addr), 1);
        chk("lp_v1", 32'(b_valid), 0);
        cyc(4);
        chk("lp_n2", 32'(b_note), 29);
        chk("lp_a2", 32'(b_addr), 2);
        cyc(1);
        chk("lp_predone", 32'(b_done), 0);
        cyc(1);
        chk("lp_done",    32'(b_done), 1);
        chk("lp_wrap",    32'(b_addr), 0);
        chk("lp_playing", 32'(b_playing), 1);
        cyc(1);
        chk("lp_done_off", 32'(b_done), 0);
        cyc(1);
        chk("lp_n3", 32'(b_note), 29);
        chk("lp_a3", 32'(b_addr), 0);
        cyc(10);
        chk("lp_done2", 32'(b_done), 1);

        // reset mid-FETCH on instance a (index 5 just ended)
        chk("mf_addr", 32'(a_addr), 6);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("mf_rst_addr",    32'(a_addr), 0);
        chk("mf_rst_note",    32'(a_note), 0);
        chk("mf_rst_playing", 32'(a_playing), 0);
        chk("mf_rst_valid",   32'(a_valid), 0);
        pulse_pp();
        cyc(2);
        chk("mf_re_note",    32'(a_note), 29);
        chk("mf_re_addr",    32'(a_addr), 0);
        chk("mf_re_playing", 32'(a_playing), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Playback controller for the two registered note ROMs (song 1 and song 2). It generates the shared ROM address and accounts for the ROMs' one-cycle read latency. It paces steps at a fixed beat period, handles play/pause/restart/loop, and presents one latched note code per step to the downstream tone generator. It sits between the user-input debouncers and the tone generator.

Parameters:
BEAT_TICKS, 12500000, clock cycles per ROM step (note_out update period); legal range >= 4
SONG1_LEN, 84, number of valid entries in song 1 (last index SONG1_LEN-1); legal range 1..256
SONG2_LEN, 243, number of valid entries in song 2; legal range 1..256

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
play_pause  input  1  single-cycle pulse: start from IDLE, toggle pause while playing
restart  input  1  single-cycle pulse: abandon current position, start song_sel from index 0
song_sel  input  1  song choice (0 = song 1, 1 = song 2); sampled only at start/restart
loop_en  input  1  1 = wrap to index 0 at end of song, 0 = stop
rom1_note  input  8  registered data from the song 1 ROM
rom2_note  input  8  registered data from the song 2 ROM
rom_addr  output  8  address driven to both ROMs
note_out  output  8  current note code to the tone generator (0 = rest/silent)
note_valid  output  1  1 when note_out != 0 and the sequencer is not paused or idle
playing  output  1  1 in FETCH, PLAY or PAUSE
paused  output  1  1 in PAUSE
active_song  output  1  song latched at the last start/restart
song_done  output  1  one-cycle pulse on completing the last step

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = IDLE; rom_addr, note_out, cnt and active_song = 0; note_valid, playing, paused, song_done and the pending flag = 0. Reset overrides every other input, including mid-song.
- States: IDLE, FETCH, PLAY, PAUSE.
- ROM timing: the ROM samples rom_addr at edge E+1 after the controller sets it at edge E. The data is captured into note_out at edge E+2. FETCH therefore lasts exactly 2 cycles.
- Selected data = active_song ? rom2_note : rom1_note.
- Step length: len = active_song ? SONG2_LEN : SONG1_LEN.
- IDLE:
  - On play_pause or restart: active_song <= song_sel, rom_addr <= 0, cnt <= 0, state -> FETCH.
  - note_out stays 0.
- FETCH:
  - 2 cycles; note_out holds the previous step's value.
  - On the 2nd cycle: note_out <= selected data, state -> PLAY.
  - A play_pause pulse during FETCH sets pending; it is applied on the first PLAY cycle.
- PLAY:
  - cnt increments every cycle. The step ends when the cycle count since the last note_out update reaches BEAT_TICKS - 2.
  - Result: note_out updates exactly every BEAT_TICKS cycles, because the next FETCH is overlapped into the period.
  - At step end, if rom_addr != len-1: rom_addr <= rom_addr+1, cnt <= 0, state -> FETCH.
  - At step end, if rom_addr == len-1:
    - song_done pulses for 1 cycle.
    - loop_en = 1: rom_addr <= 0, FETCH.
    - loop_en = 0: state -> IDLE, rom_addr <= 0, note_out <= 0.
- Pause and restart priority:
  - play_pause (or pending) in PLAY: state -> PAUSE; cnt and rom_addr frozen.
  - In PAUSE: note_valid = 0, and note_out retains its value for resume.
  - play_pause in PAUSE: back to PLAY; cnt resumes from its frozen value.
  - restart in any non-IDLE state: same action as the IDLE start; it clears pending and suppresses song_done.
  - restart has priority over play_pause on the same cycle.
  - restart coinciding with a step end: restart wins; no song_done.
- song_sel and loop_en changes mid-song:
  - song_sel changes take effect only at the next start/restart.
  - loop_en is sampled at step end of the last index.
- Arithmetic:
  - rom_addr is an 8-bit counter; len-1 compares in 8 bits, so len = 256 ends at index 255.
  - cnt must be wide enough to hold BEAT_TICKS-1 (clog2).
- Outputs are all registered except note_valid, which is (note_out != 0) & (state == FETCH or PLAY).

Test Plan:
1. BEAT_TICKS=4, SONG1_LEN=84, song_sel=0, play_pause pulse at cycle 0 -> rom_addr = 0, note_out = 29 at cycle 2. note_out then follows 0, 29, 0, 29, 0, 34 every 4 cycles; note_valid is low on the 0 entries.
2. Song 2 with loop_en=0, run to end -> after index 242, song_done pulses once. State returns to IDLE with note_out = 0 and playing = 0; the last audible note before the end is 25 (index 240).
3. loop_en=1, SONG1_LEN=3 -> addresses cycle 0,1,2,0,1,... with note_out 29, 0, 29, 29, ...; song_done pulses at each wrap.
4. Pause in PLAY at cnt=1 of index 6, hold 10 cycles, resume -> rom_addr stays 6 and note_valid = 0 while paused. note_out = 34 is preserved; the remaining step length after resume is exactly the unexpired cycles.
5. Restart with song_sel=1 during song 1 index 20, asserted together with play_pause -> active_song = 1, rom_addr = 0, note_out = 25 two cycles later, paused = 0.
6. rst_n=0 for one cycle mid-FETCH -> all outputs return to reset values next cycle. A following play_pause restarts cleanly from index 0.
